// File: rtl/product_bcd_converter_pkg.sv
// rtl/product_bcd_converter_pkg.sv - shared types, adjust constants and counter sizing for the BCD converter
package product_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] ADJ_ADD       = 4'd3;

  // Counter must hold WORD_LENGTH itself, not just WORD_LENGTH-1.
  function automatic int cnt_width(input int word_length);
    return $clog2(word_length + 1);
  endfunction

endpackage

// File: rtl/product_bcd_converter_if.sv
// rtl/product_bcd_converter_if.sv - start/ready request and registered BCD result bundle
interface product_bcd_converter_if #(
  parameter int WORD_LENGTH = 16,
  parameter int BCD_DIGITS  = 5
);
  logic                     start;
  logic                     Sign;
  logic [WORD_LENGTH-1:0]   Magnitude;
  logic                     ready;
  logic                     done;
  logic [4*BCD_DIGITS-1:0]  BCD;
  logic                     Sign_out;

  modport master (
    output start, Sign, Magnitude,
    input  ready, done, BCD, Sign_out
  );

  modport slave (
    input  start, Sign, Magnitude,
    output ready, done, BCD, Sign_out
  );
endinterface

// File: rtl/product_bcd_converter_adjust.sv
// rtl/product_bcd_converter_adjust.sv - double-dabble digit correction, +3 when the digit is 5 or more
module bcd_digit_adjust
  import product_bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= ADJ_THRESHOLD) ? digit_in + ADJ_ADD : digit_in;

endmodule

// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int BCD_DIGITS  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  product_bcd_converter_if.slave  bus
);

  localparam int CW = cnt_width(WORD_LENGTH);
  localparam int BW = 4 * BCD_DIGITS;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WORD_LENGTH-1:0] bin;
  logic [BW-1:0]          work;
  logic [BW-1:0]          work_adj;
  logic [BW+WORD_LENGTH-1:0] shifted;
  logic                   sign_hold;
  logic                   nonzero_hold;
  logic                   ready_q;
  logic                   done_q;
  logic [BW-1:0]          bcd_q;
  logic                   sign_q;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (work[4*g +: 4]),
      .digit_out (work_adj[4*g +: 4])
    );
  end

  assign shifted = {work_adj, bin} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bin          <= '0;
      work         <= '0;
      sign_hold    <= 1'b0;
      nonzero_hold <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      bcd_q        <= '0;
      sign_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin          <= bus.Magnitude;
            sign_hold    <= bus.Sign;
            nonzero_hold <= |bus.Magnitude;
            work         <= '0;
            cnt          <= CW'(WORD_LENGTH);
            ready_q      <= 1'b0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          {work, bin} <= shifted;
          cnt         <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            // Negative zero is reported as +0.
            bcd_q   <= shifted[BW+WORD_LENGTH-1 -: BW];
            sign_q  <= sign_hold & nonzero_hold;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.BCD      = bcd_q;
  assign bus.Sign_out = sign_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - randomized and directed self-checking bench for product_bcd_converter
module tb_product_bcd_converter;

  localparam int WL = 16;
  localparam int BD = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  product_bcd_converter_if #(.WORD_LENGTH(WL), .BCD_DIGITS(BD)) bus ();

  product_bcd_converter #(.WORD_LENGTH(WL), .BCD_DIGITS(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*BD-1:0] bcd_ref(input int unsigned m);
    logic [4*BD-1:0] r;
    int unsigned v;
    r = '0;
    v = m;
    for (int i = 0; i < BD; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Call at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_conv(input logic s, input logic [WL-1:0] m);
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start     = 1'b1;
    bus.Sign      = s;
    bus.Magnitude = m;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit chk_ready, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (chk_ready) check("ready_busy", 32'(bus.ready), 32'd0);
    end
  endtask

  task automatic conv(input logic s, input logic [WL-1:0] m);
    int lat;
    start_conv(s, m);
    wait_done(40, 1'b1, lat);
    check("latency", 32'(lat), 32'(WL));
    check("bcd", 32'(bus.BCD), 32'(bcd_ref(m)));
    check("sign_out", 32'(bus.Sign_out), 32'(s && (m != 0)));
    @(negedge clk);
    check("done_single_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [4*BD-1:0] first_bcd;
    logic s;
    logic [WL-1:0] m;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.Sign = 1'b0;
    bus.Magnitude = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.BCD), 32'd0);
    check("rst_sign", 32'(bus.Sign_out), 32'd0);

    conv(1'b0, 16'd12);
    conv(1'b1, 16'hFFFF);
    conv(1'b0, 16'd0);
    conv(1'b0, 16'd9);
    conv(1'b0, 16'd10);
    conv(1'b0, 16'd99);
    conv(1'b1, 16'd0);

    // Start while busy is dropped; input changes after acceptance are ignored.
    start_conv(1'b0, 16'd1234);
    pulses = 0;
    lat = -1;
    first_bcd = '0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 3) begin bus.start = 1'b1; bus.Magnitude = 16'd999; end
      if (n == 4) bus.start = 1'b0;
      if (n == 5) bus.Magnitude = 16'd777;
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (lat < 0) begin lat = n; first_bcd = bus.BCD; end
      end
    end
    check("ignored_pulses", 32'(pulses), 32'd1);
    check("ignored_latency", 32'(lat), 32'(WL));
    check("ignored_bcd", 32'(first_bcd), 32'(bcd_ref(1234)));

    // Back-to-back: new start in the done cycle.
    start_conv(1'b0, 16'd42);
    wait_done(40, 1'b0, lat);
    check("b2b_first_latency", 32'(lat), 32'(WL));
    check("b2b_first_bcd", 32'(bus.BCD), 32'(bcd_ref(42)));
    start_conv(1'b0, 16'd7);
    wait_done(40, 1'b1, lat);
    check("b2b_second_latency", 32'(lat), 32'(WL));
    check("b2b_second_bcd", 32'(bus.BCD), 32'(bcd_ref(7)));
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: m = WL'($urandom_range(0, 20));
        1: m = WL'($urandom_range(90, 1100));
        default: m = WL'($urandom);
      endcase
      conv(s, m);
    end

    // Reset mid-conversion aborts with no done.
    conv(1'b1, 16'd5);
    start_conv(1'b0, 16'd500);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bcd", 32'(bus.BCD), 32'd0);
    check("abort_sign", 32'(bus.Sign_out), 32'd0);
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    conv(1'b0, 16'd3);

    // Reset and start together: start is dropped.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.Magnitude = 16'd321;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    check("rst_start_ready", 32'(bus.ready), 32'd1);
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("rst_start_no_done", 32'(pulses), 32'd0);
    check("rst_start_bcd", 32'(bus.BCD), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
